// File: rtl/clk_div_dec.sv
// rtl/clk_div_dec.sv - dual-modulus fractional clock divider (DIV_INT + DIV_FRAC/10)
module clk_div_dec #(
  parameter int DIV_INT  = 4,
  parameter int DIV_FRAC = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic clk_div
);

  // Reject ratios outside the supported range at elaboration time
  generate
    if (DIV_INT < 2 || DIV_INT > 255) begin : g_bad_div_int
      $error("clk_div_dec: DIV_INT must be in 2..255");
    end
    if (DIV_FRAC < 0 || DIV_FRAC > 9) begin : g_bad_div_frac
      $error("clk_div_dec: DIV_FRAC must be in 0..9");
    end
  endgenerate

  // Period lengths need 9 bits because DIV_INT+1 can reach 256
  localparam logic [8:0] P_SHORT = 9'(DIV_INT);
  localparam logic [8:0] P_LONG  = 9'(DIV_INT + 1);
  localparam logic [4:0] FRAC    = 5'(DIV_FRAC);

  logic [7:0] cnt;       // position inside the current period, 0..P-1
  logic [3:0] acc;       // fractional error accumulator, 0..9
  logic [8:0] per_len;   // length P of the period in progress
  logic       running;   // a period is in progress

  logic [4:0] sum;
  logic [4:0] sum_m10;
  logic       long_sel;
  logic [3:0] next_acc;
  logic [8:0] next_len;
  logic       wrap;
  logic [7:0] cnt_inc;

  // Choose the next period length from the accumulator and detect period end
  always_comb begin
    sum      = {1'b0, acc} + FRAC;
    sum_m10  = sum - 5'd10;
    long_sel = (sum >= 5'd10);
    next_acc = long_sel ? sum_m10[3:0] : sum[3:0];
    next_len = long_sel ? P_LONG : P_SHORT;
    wrap     = running && ({1'b0, cnt} == (per_len - 9'd1));
    cnt_inc  = cnt + 8'd1;
  end

  // Restart has priority over counting; a new period always opens with a high cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= 8'd0;
      acc     <= 4'd0;
      per_len <= P_SHORT;
      running <= 1'b0;
      clk_div <= 1'b0;
    end else if (load) begin
      cnt     <= 8'd0;
      acc     <= 4'd0;
      per_len <= P_SHORT;
      running <= 1'b0;
      clk_div <= 1'b0;
    end else if (!running || wrap) begin
      cnt     <= 8'd0;
      acc     <= next_acc;
      per_len <= next_len;
      running <= 1'b1;
      clk_div <= 1'b1;
    end else begin
      cnt     <= cnt_inc;
      // High while the upcoming position is below floor(P/2)
      clk_div <= ({1'b0, cnt_inc} < {1'b0, per_len[8:1]});
    end
  end

endmodule

// File: tb/tb_clk_div_dec.sv
// tb/tb_clk_div_dec.sv - randomized self-checking bench for clk_div_dec
module tb_clk_div_dec;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic       load = 1'bx;
  logic [3:0] div;

  int n_total = 0;
  int n_pass  = 0;
  int pos [4];
  int di  [4] = '{4, 3, 4, 2};
  int df  [4] = '{5, 0, 3, 9};
  int c_hist [44];
  int rises;

  always #2 clk = ~clk;

  clk_div_dec #(.DIV_INT(4), .DIV_FRAC(5)) u_a (.clk(clk), .rstn(rstn), .load(load), .clk_div(div[0]));
  clk_div_dec #(.DIV_INT(3), .DIV_FRAC(0)) u_b (.clk(clk), .rstn(rstn), .load(load), .clk_div(div[1]));
  clk_div_dec #(.DIV_INT(4), .DIV_FRAC(3)) u_c (.clk(clk), .rstn(rstn), .load(load), .clk_div(div[2]));
  clk_div_dec #(.DIV_INT(2), .DIV_FRAC(9)) u_d (.clk(clk), .rstn(rstn), .load(load), .clk_div(div[3]));

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Period k is long when the running total k*F/10 crosses an integer during it
  function automatic int exp_div(input int d_int, input int d_frac, input int t);
    int k;
    int start;
    int p;
    k = 0;
    start = 0;
    while (1) begin
      p = d_int + ((k + 1) * d_frac / 10 - k * d_frac / 10);
      if (t < start + p) return ((t - start) < (p / 2)) ? 1 : 0;
      start += p;
      k++;
    end
  endfunction

  function automatic int model_out(input int i);
    return (pos[i] < 0) ? 0 : exp_div(di[i], df[i], pos[i]);
  endfunction

  // Advance the model on a rising edge, then compare all four dividers
  task automatic step_and_check();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rstn === 1'b1) begin
        if (load === 1'b1) pos[i] = -1;
        else pos[i] = pos[i] + 1;
      end else begin
        pos[i] = -1;
      end
    end
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("div%0d_pos%0d", i, pos[i]), int'(div[i]), model_out(i));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pos[i] = -1;

    #1 rstn = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) check($sformatf("reset_div%0d", i), int'(div[i]), 0);

    @(negedge clk);
    rstn = 1'b1;
    load = 1'b1;
    step_and_check();
    @(negedge clk);
    load = 1'b0;

    // Uninterrupted run: waveform, frame length and constant accumulator
    for (int c = 0; c < 120; c++) begin
      step_and_check();
      if (c < 44) c_hist[c] = int'(div[2]);
      if (c % 10 == 0) check("acc_frac0", int'(u_b.acc), 0);
      @(negedge clk);
    end
    rises = 0;
    for (int c = 0; c < 43; c++)
      if (c_hist[c] == 1 && (c == 0 || c_hist[c-1] == 0)) rises++;
    check("frame43_rises", rises, 10);
    check("frame43_next_rise", c_hist[43], 1);
    check("frame43_prev_low", c_hist[42], 0);

    // Random load pulses and asynchronous resets dropped during a high phase
    for (int c = 0; c < 3000; c++) begin
      step_and_check();
      if (pos[0] >= 0 && model_out(0) == 1 && $urandom_range(0, 39) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("async_rst_div%0d", i), int'(div[i]), 0);
        for (int i = 0; i < 4; i++) pos[i] = -1;
        rstn = 1'b1;
        load = 1'b0;
      end else begin
        @(negedge clk);
        load = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
